// File: rtl/chiplet_types_pkg.sv
// Shared flit and transmit-port types for the chiplet link.
package chiplet_types_pkg;

    localparam int FLIT_VC_W      = 1;
    localparam int FLIT_PAYLOAD_W = 31;

    typedef struct packed {
        logic [FLIT_VC_W-1:0]      vc;
        logic [FLIT_PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_CREDIT = 2'd1,
        SEND        = 2'd2
    } tx_port_state_t;

endpackage

// File: rtl/socetlib_fifo.sv
// Synchronous show-ahead FIFO; rdata_o is the current head whenever empty_o is low.
`default_nettype none

module socetlib_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push while full is dropped even if a pop happens the same cycle.
    assign full_o  = (count_q == CNTW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/flit_tx_port.sv
// Credit-based flit transmit port: staging FIFO, output register and per-VC credit counters.
// Optional FLIT_TX_PORT_PERF_EN adds sent_count / stall_count performance counters.
`default_nettype none

module flit_tx_port
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS    = 2,
    parameter int CREDITS    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic                                     in_valid,
    input  flit_t                                    in_flit,
    output logic                                     in_ready,
    output logic                                     data_ready_out,
    output flit_t                                    out_flit,
    input  logic                                     packet_sent,
    input  logic [NUM_VCS-1:0]                       credit_granted,
    output logic [NUM_VCS-1:0][$clog2(CREDITS+1)-1:0] credits,
    output logic                                     credit_err
`ifdef FLIT_TX_PORT_PERF_EN
    ,
    output logic [31:0]                              sent_count,
    output logic [31:0]                              stall_count
`endif
);
    localparam int CW = $clog2(CREDITS + 1);

    tx_port_state_t             state_q, state_d;
    flit_t                      out_flit_q, out_flit_d;
    logic [NUM_VCS-1:0][CW-1:0] credits_q, credits_d;
    logic                       credit_err_q, credit_err_d;

    flit_t fifo_head;
    logic  fifo_empty, fifo_full, fifo_pop;
    logic  accept, head_has_credit, out_has_credit;

    socetlib_fifo #(
        .WIDTH ($bits(flit_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (in_valid),
        .pop_i   (fifo_pop),
        .wdata_i (in_flit),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready       = !fifo_full;
    assign data_ready_out = (state_q == SEND);
    assign out_flit       = out_flit_q;
    assign credits        = credits_q;
    assign credit_err     = credit_err_q;
    assign accept         = (state_q == SEND) && packet_sent;

    // A grant and a send on the same VC cancel; a lone grant at the ceiling saturates and flags.
    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (credit_granted[v] && !(accept && int'(out_flit_q.vc) == v)) begin
                if (credits_q[v] == CW'(CREDITS)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d[v] = credits_q[v] + CW'(1);
                end
            end else if (!credit_granted[v] && accept && int'(out_flit_q.vc) == v
                         && credits_q[v] != '0) begin
                credits_d[v] = credits_q[v] - CW'(1);
            end
        end
    end

    // SEND/WAIT decisions look at post-update credits so a grant this cycle counts.
    always_comb begin
        head_has_credit = 1'b0;
        out_has_credit  = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (int'(fifo_head.vc) == v && credits_d[v] != '0) begin
                head_has_credit = 1'b1;
            end
            if (int'(out_flit_q.vc) == v && credits_d[v] != '0) begin
                out_has_credit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        out_flit_d = out_flit_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    out_flit_d = fifo_head;
                    state_d    = head_has_credit ? SEND : WAIT_CREDIT;
                end
            end
            WAIT_CREDIT: begin
                if (out_has_credit) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (packet_sent) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        out_flit_d = fifo_head;
                        state_d    = head_has_credit ? SEND : WAIT_CREDIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            out_flit_q   <= '0;
            credit_err_q <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) begin
                credits_q[v] <= CW'(CREDITS);
            end
        end else begin
            state_q      <= state_d;
            out_flit_q   <= out_flit_d;
            credit_err_q <= credit_err_d;
            credits_q    <= credits_d;
        end
    end

`ifdef FLIT_TX_PORT_PERF_EN
    logic [31:0] sent_count_q, stall_count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sent_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            if (accept) begin
                sent_count_q <= sent_count_q + 32'd1;
            end
            if (state_q == WAIT_CREDIT) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign sent_count  = sent_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: doc/flit_tx_port.md
FLIT_TX_PORT -- requirements
Module: flit_tx_port

Interface
REQ-001 Parameter NUM_VCS, 2, number of virtual channels; flit metadata.vc indexes 0..NUM_VCS-1.
REQ-002 Parameter CREDITS, 4, receiver buffer slots per VC; initial and maximum credit count.
REQ-003 Parameter FIFO_DEPTH, 4, local flit staging FIFO depth.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low (clk, n_rst).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream flit offered.
REQ-008 in_flit  input  $bits(flit_t)  upstream flit.
REQ-009 in_ready  output  1  FIFO not full; push occurs when in_valid && in_ready.
REQ-010 data_ready_out  output  1  out_flit valid toward receiver.
REQ-011 out_flit  output  $bits(flit_t)  flit presented to receiver.
REQ-012 packet_sent  input  1  receiver accepted out_flit this cycle.
REQ-013 credit_granted  input  NUM_VCS  per-VC one-cycle credit-return pulses.
REQ-014 credits  output  NUM_VCS x $clog2(CREDITS+1)  current credit count per VC.
REQ-015 credit_err  output  1  sticky; a credit was returned to a VC already at CREDITS.

Function
REQ-016 Staging FIFO SHALL accept one flit per cycle when not full; in_valid while full SHALL be ignored, no flit lost from FIFO.
REQ-017 FSM states SHALL be IDLE, WAIT_CREDIT, SEND; out_flit is a register loaded from FIFO head.
REQ-018 IDLE: if FIFO non-empty, pop head into out_flit; next state SEND if credits[head.vc] > 0, else WAIT_CREDIT.
REQ-019 WAIT_CREDIT: data_ready_out = 0; move to SEND the cycle after credits[out_flit.vc] > 0 (a grant in cycle N gives SEND in N+1).
REQ-020 SEND: data_ready_out = 1; hold out_flit stable until packet_sent.
REQ-021 On SEND && packet_sent: decrement credits[out_flit.vc]; if FIFO non-empty, pop next head same cycle and choose SEND/WAIT_CREDIT using post-update credits of the new VC; else go IDLE.
REQ-022 Back-to-back acceptance SHALL sustain one flit per cycle while credits allow; first flit pushed into empty block at cycle N is visible on data_ready_out at N+2.
REQ-023 packet_sent while data_ready_out = 0 SHALL be ignored.
REQ-024 credit_granted[v] SHALL increment credits[v]; simultaneous grant and decrement on same v leaves it unchanged.
REQ-025 Grant to a VC at CREDITS (without same-cycle decrement) SHALL saturate and set credit_err until reset.
REQ-026 Credits SHALL never go below 0; SEND is never entered with zero credit for out_flit.vc.

Reset
REQ-027 On n_rst low: state IDLE, FIFO empty, out_flit 0, data_ready_out 0, in_ready 1 after reset, credits[all] = CREDITS, credit_err 0, counters 0.
REQ-028 Reset mid-transfer SHALL discard the FIFO and out_flit; no partial flit presented after release.

Configuration
REQ-029 Macro FLIT_TX_PORT_PERF_EN defined: add outputs sent_count (32b, +1 per accepted flit) and stall_count (32b, +1 per cycle in WAIT_CREDIT), both wrap at 2^32.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 flit_t and a tx_port_state_t enum (IDLE, WAIT_CREDIT, SEND) SHALL live in chiplet_types_pkg.
REQ-032 Staging FIFO SHALL be a socetlib_fifo instance of width $bits(flit_t), depth FIFO_DEPTH; no other sub-modules.

Verification
REQ-033 Push 4 flits vc0, packet_sent held 1 -> 4 accepts on consecutive cycles, credits[0] 4->0.
REQ-034 Push 5th flit vc0 with credits[0]=0 -> WAIT_CREDIT, data_ready_out 0; pulse credit_granted[0] -> data_ready_out 1 next cycle.
REQ-035 Accept flit vc1 with same-cycle credit_granted[1] -> credits[1] unchanged at 3.
REQ-036 credit_granted[0] with credits[0]=4 -> credits[0] stays 4, credit_err 1 until reset.
REQ-037 Fill FIFO (4) with packet_sent 0 -> in_ready 0, 6th in_valid ignored, all 5 flits later delivered in order.
REQ-038 Assert n_rst during SEND -> data_ready_out 0 immediately, credits all 4, FIFO empty.
